// File: rtl/grid_cursor_ctl.sv
// Grid-snapped board cursor: synchronizes player buttons, moves a clamped col/row on
// frame ticks with hold-to-repeat, and produces a blinking draw enable and a fire strobe.
module grid_cursor_ctl #(
   parameter int GRID_X0      = 32,
   parameter int GRID_Y0      = 32,
   parameter int CELL_W       = 48,
   parameter int CELL_H       = 48,
   parameter int GRID_COLS    = 10,
   parameter int GRID_ROWS    = 10,
   parameter int REPEAT_DELAY = 20,
   parameter int REPEAT_RATE  = 6,
   parameter int BLINK_PERIOD = 32,
   parameter int BLINK_ON     = 24
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        vsync,
   input  logic        active,
   input  logic        btn_up,
   input  logic        btn_down,
   input  logic        btn_left,
   input  logic        btn_right,
   input  logic        btn_fire,
   output logic [3:0]  col,
   output logic [3:0]  row,
   output logic [11:0] x_pos,
   output logic [11:0] y_pos,
   output logic        enable,
   output logic        fire_pulse
);

   localparam int DLY_W   = $clog2(REPEAT_DELAY + 1);
   localparam int RATE_W  = $clog2(REPEAT_RATE + 1);
   localparam int BLINK_W = $clog2(BLINK_PERIOD + 1);

   localparam logic [3:0]         COL_MAX   = 4'(GRID_COLS - 1);
   localparam logic [3:0]         ROW_MAX   = 4'(GRID_ROWS - 1);
   localparam logic [DLY_W-1:0]   DLY_LAST  = DLY_W'(REPEAT_DELAY - 1);
   localparam logic [RATE_W-1:0]  RATE_LAST = RATE_W'(REPEAT_RATE - 1);
   localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_PERIOD - 1);
   localparam logic [BLINK_W-1:0] BLINK_VIS = BLINK_W'(BLINK_ON);

   typedef enum logic [2:0] {DIR_NONE, DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;
   typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

   // Button order in the synchronizer vectors: {fire, up, down, left, right}
   logic [4:0] btn_s1, btn_s2;
   logic       vsync_q, fire_q;
   logic       tick, fire_edge;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         btn_s1  <= '0;
         btn_s2  <= '0;
         vsync_q <= 1'b0;
         fire_q  <= 1'b0;
      end else begin
         btn_s1  <= {btn_fire, btn_up, btn_down, btn_left, btn_right};
         btn_s2  <= btn_s1;
         vsync_q <= vsync;
         fire_q  <= btn_s2[4];
      end
   end

   assign tick      = vsync & ~vsync_q;
   assign fire_edge = btn_s2[4] & ~fire_q;

   dir_t dir;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      dir = DIR_NONE;
      if (btn_s2[3])      dir = DIR_UP;
      else if (btn_s2[2]) dir = DIR_DOWN;
      else if (btn_s2[1]) dir = DIR_LEFT;
      else if (btn_s2[0]) dir = DIR_RIGHT;
   end

   logic [3:0] col_mv, row_mv;

   always_comb begin
      col_mv = col;
      row_mv = row;
      unique case (dir)
         DIR_UP:    row_mv = (row == 4'd0)    ? row : row - 4'd1;
         DIR_DOWN:  row_mv = (row == ROW_MAX) ? row : row + 4'd1;
         DIR_LEFT:  col_mv = (col == 4'd0)    ? col : col - 4'd1;
         DIR_RIGHT: col_mv = (col == COL_MAX) ? col : col + 4'd1;
         default: ;
      endcase
   end

   state_t              state, state_nx;
   logic [DLY_W-1:0]    delay_cnt, delay_nx;
   logic [RATE_W-1:0]   rate_cnt, rate_nx;
   logic                do_move;

   always_comb begin
      state_nx = state;
      delay_nx = delay_cnt;
      rate_nx  = rate_cnt;
      do_move  = 1'b0;
      if (!active) begin
         state_nx = IDLE;
         delay_nx = '0;
         rate_nx  = '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (tick && dir != DIR_NONE) begin
                  do_move  = 1'b1;
                  delay_nx = '0;
                  state_nx = DELAY;
               end
            end
            DELAY: begin
               if (dir == DIR_NONE) begin
                  state_nx = IDLE;
                  delay_nx = '0;
               end else if (tick) begin
                  if (delay_cnt == DLY_LAST) begin
                     do_move  = 1'b1;
                     rate_nx  = '0;
                     state_nx = REPEAT;
                  end else begin
                     delay_nx = delay_cnt + 1'b1;
                  end
               end
            end
            REPEAT: begin
               if (dir == DIR_NONE) begin
                  state_nx = IDLE;
                  rate_nx  = '0;
               end else if (tick) begin
                  do_move = (rate_cnt == RATE_LAST);
                  rate_nx = do_move ? '0 : rate_cnt + 1'b1;
               end
            end
            default: state_nx = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         delay_cnt <= '0;
         rate_cnt  <= '0;
         col       <= 4'd0;
         row       <= 4'd0;
      end else begin
         state     <= state_nx;
         delay_cnt <= delay_nx;
         rate_cnt  <= rate_nx;
         if (do_move) begin
            col <= col_mv;
            row <= row_mv;
         end
      end
   end

   // Pixel position follows col/row by one clock; computed at int width then truncated.
   always_ff @(posedge clk) begin
      if (rst) begin
         x_pos <= 12'(GRID_X0);
         y_pos <= 12'(GRID_Y0);
      end else begin
         x_pos <= 12'(GRID_X0 + int'(col) * CELL_W);
         y_pos <= 12'(GRID_Y0 + int'(row) * CELL_H);
      end
   end

   logic [BLINK_W-1:0] blink_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         blink_cnt  <= '0;
         enable     <= 1'b0;
         fire_pulse <= 1'b0;
      end else begin
         if (!active)
            blink_cnt <= '0;
         else if (tick)
            blink_cnt <= (blink_cnt == BLINK_MAX) ? '0 : blink_cnt + 1'b1;
         enable     <= active && (blink_cnt < BLINK_VIS);
         fire_pulse <= active && fire_edge;
      end
   end

endmodule

// File: tb/tb_grid_cursor_ctl.sv
// Scoreboard bench for grid_cursor_ctl: frame-level reference model feeds expectation
// queues; independent monitors compare cursor state after each tick and every fire strobe.
module tb_grid_cursor_ctl;

   localparam int X0 = 32, Y0 = 32, CW = 48, CH = 48, COLS = 10, ROWS = 10;
   localparam int DLY = 20, RATE = 6, PER = 32, ON = 24;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        vsync = 1'b0, active = 1'b0;
   logic        btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0, btn_fire = 1'b0;
   logic [3:0]  col, row;
   logic [11:0] x_pos, y_pos;
   logic        enable, fire_pulse;

   grid_cursor_ctl dut (
      .clk(clk), .rst(rst), .vsync(vsync), .active(active),
      .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
      .btn_fire(btn_fire), .col(col), .row(row), .x_pos(x_pos), .y_pos(y_pos),
      .enable(enable), .fire_pulse(fire_pulse)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0, checks = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   typedef struct {int c; int r; int x; int y; int en;} exp_t;
   exp_t exp_q[$];
   int   fire_q[$];

   // Reference model state: cursor cell, consecutive held ticks, ticks since active rose
   int   m_col = 0, m_row = 0, m_hold = 0, m_blink = 0;
   bit   m_fire = 1'b0;
   int   mon_prev_x = X0;

   function automatic bit move_due(input int n);
      return (n == 1) || (n == 1 + DLY) || (n > 1 + DLY && (n - 1 - DLY) % RATE == 0);
   endfunction

   // One frame: set inputs, let the synchronizers settle, then pulse vsync.
   // Fire (if any) is raised so its synchronized edge lands on the tick cycle.
   task automatic frame(input int d, input bit f, input bit a);
      exp_t e;
      @(negedge clk);
      btn_up = d[3]; btn_down = d[2]; btn_left = d[1]; btn_right = d[0];
      active = a;
      repeat (2) @(negedge clk);
      btn_fire = f;
      if (f && !m_fire && a) fire_q.push_back(cyc + 3);
      m_fire = f;
      if (a && d[3:0] != 0) begin
         m_hold++;
         if (move_due(m_hold)) begin
            if (d[3])      m_row = (m_row > 0) ? m_row - 1 : 0;
            else if (d[2]) m_row = (m_row < ROWS - 1) ? m_row + 1 : ROWS - 1;
            else if (d[1]) m_col = (m_col > 0) ? m_col - 1 : 0;
            else           m_col = (m_col < COLS - 1) ? m_col + 1 : COLS - 1;
         end
      end else begin
         m_hold = 0;
      end
      m_blink = a ? (m_blink + 1) % PER : 0;
      e.c = m_col; e.r = m_row; e.x = X0 + m_col * CW; e.y = Y0 + m_row * CH;
      e.en = (a && m_blink < ON) ? 1 : 0;
      exp_q.push_back(e);
      repeat (2) @(negedge clk);
      vsync = 1'b1;
      repeat (2) @(negedge clk);
      vsync = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic fire_hold(input bit a);
      @(negedge clk);
      btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
      m_hold = 0;
      active = a;
      if (!a) m_blink = 0;
      btn_fire = 1'b1;
      if (a && !m_fire) fire_q.push_back(cyc + 3);
      m_fire = 1'b1;
      repeat (100) @(negedge clk);
      btn_fire = 1'b0;
      m_fire = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   // Reset with every button pressed; outputs must be at reset values after one edge and stay there.
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      active = 1'b0;
      btn_up = 1; btn_down = 1; btn_left = 1; btn_right = 1; btn_fire = 1;
      @(negedge clk);
      check("rst_col", col, 0);
      check("rst_row", row, 0);
      check("rst_x", x_pos, X0);
      check("rst_y", y_pos, Y0);
      check("rst_enable", enable, 0);
      check("rst_fire", fire_pulse, 0);
      repeat (4) @(negedge clk);
      check("rst_hold_col", col, 0);
      check("rst_hold_x", x_pos, X0);
      rst = 1'b0;
      btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0; btn_fire = 0;
      m_col = 0; m_row = 0; m_hold = 0; m_blink = 0; m_fire = 1'b0;
      mon_prev_x = X0;
   endtask

   // Tick monitor: col must change on the tick edge with x_pos one clock behind.
   initial begin
      logic prev = 1'b0;
      exp_t e;
      forever begin
         @(posedge clk);
         if (!rst && vsync && !prev) begin
            if (exp_q.size() == 0) begin
               check("tick_unexpected", exp_q.size(), 1);
            end else begin
               e = exp_q.pop_front();
               @(negedge clk);
               check("col_at_tick", col, e.c);
               check("x_lags_col", x_pos, mon_prev_x);
               repeat (2) @(negedge clk);
               check("col", col, e.c);
               check("row", row, e.r);
               check("x_pos", x_pos, e.x);
               check("y_pos", y_pos, e.y);
               check("enable", enable, e.en);
               mon_prev_x = e.x;
            end
         end
         prev = vsync;
      end
   end

   // Fire monitor: each strobe must match an expected cycle; back-to-back highs hit an empty queue.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst && fire_pulse) begin
            if (fire_q.size() == 0) check("fire_spurious", fire_pulse, 0);
            else check("fire_cycle", cyc, fire_q.pop_front());
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      int d;
      do_reset();
      frame(0, 0, 1);                           // no move after reset release
      frame(4'b0001, 0, 1);                     // single tap right
      frame(0, 0, 1);
      for (int i = 0; i < 30; i++) frame(4'b0001, 0, 1);   // auto-repeat
      frame(0, 0, 1);
      for (int i = 0; i < 40; i++) frame(4'b0001, 0, 1);   // clamp at right edge
      frame(0, 0, 1);
      frame(4'b1010, 0, 1);                     // up+left: up wins, clamps at row 0
      frame(0, 0, 0);
      for (int i = 0; i < 64; i++) frame(0, 0, 1);         // blink pattern
      @(negedge clk);
      active = 1'b0;
      m_blink = 0;
      m_hold = 0;
      @(negedge clk);
      check("enable_drop", enable, 0);
      for (int i = 0; i < 4; i++) frame(4'b0100, 0, 0);    // presses ignored while inactive
      fire_hold(1'b1);
      fire_hold(1'b0);
      frame(4'b0100, 1, 1);                     // tick and fire edge in the same cycle
      frame(0, 0, 1);
      d = 0;
      for (int i = 0; i < 200; i++) begin
         if ($urandom_range(0, 3) == 0) d = $urandom_range(0, 15);
         frame(d, $urandom_range(0, 2) == 0, $urandom_range(0, 9) != 0);
      end
      for (int i = 0; i < 8; i++) frame(4'b0010, 0, 1);
      do_reset();                               // mid-operation reset
      frame(0, 0, 1);
      repeat (10) @(negedge clk);
      check("exp_queue_drained", exp_q.size(), 0);
      check("fire_queue_drained", fire_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/grid_cursor_ctl.md
Name: grid_cursor_ctl

Overview:
Upstream position/enable source for the sprite-drawing stage of the warships board view. Turns player direction/fire buttons into a grid-snapped cursor (column/row of a GRID_COLS x GRID_ROWS board). It emits the pixel position of the cursor cell's top-left corner, a blinking enable and a one-clock fire strobe. All state advances on the frame tick derived from the VGA vsync, so the cursor never moves mid-frame.

Parameters:
GRID_X0, 32, pixel x of column 0 left edge
GRID_Y0, 32, pixel y of row 0 top edge
CELL_W, 48, cell width in pixels
CELL_H, 48, cell height in pixels
GRID_COLS, 10, number of columns (2..16)
GRID_ROWS, 10, number of rows (2..16)
REPEAT_DELAY, 20, frames a direction must be held before auto-repeat starts
REPEAT_RATE, 6, frames between auto-repeat moves
BLINK_PERIOD, 32, blink period in frames
BLINK_ON, 24, frames per period during which enable is high

Ports:
clk  in  1  pixel clock
rst  in  1  synchronous, active-high reset
vsync  in  1  VGA vsync, clk-domain
active  in  1  cursor active (player's turn)
btn_up  in  1  raw button, asynchronous
btn_down  in  1  raw button, asynchronous
btn_left  in  1  raw button, asynchronous
btn_right  in  1  raw button, asynchronous
btn_fire  in  1  raw button, asynchronous
col  out  4  current cursor column
row  out  4  current cursor row
x_pos  out  12  GRID_X0 + col*CELL_W
y_pos  out  12  GRID_Y0 + row*CELL_H
enable  out  1  cursor draw enable (blinking)
fire_pulse  out  1  one-clock strobe on fire press

Behaviour:
- Reset values: col=0, row=0, x_pos=GRID_X0, y_pos=GRID_Y0, enable=0, fire_pulse=0. FSM=IDLE, all counters 0, synchronizer and edge registers 0.
- Buttons pass through 2-FF synchronizers. Logic uses only the synchronized values (2-clk input latency).
- Frame tick: single-clk pulse when vsync=1 and the registered previous vsync=0.
- Direction select (combinational, synchronized): up > down > left > right. Only one direction is applied per move.
- Move: apply the selected direction to col/row with clamping, no wrap. col saturates at 0 and GRID_COLS-1; row saturates at 0 and GRID_ROWS-1.
- col/row update at the clock edge that ends the tick cycle.
- FSM states IDLE, DELAY, REPEAT:
  - IDLE: on tick with any direction held -> move, delay_cnt=0, go DELAY.
  - DELAY: no direction held (any cycle) -> IDLE. On tick: if delay_cnt==REPEAT_DELAY-1 -> move, rate_cnt=0, go REPEAT; else delay_cnt++.
  - REPEAT: no direction held -> IDLE. On tick: if rate_cnt==REPEAT_RATE-1 -> move, rate_cnt=0; else rate_cnt++.
  - Net effect of a continuous hold: moves on hold tick 1, tick 1+REPEAT_DELAY, then every REPEAT_RATE ticks.
  - Changing direction while held does not restart timing; the next move uses the new direction.
  - active=0 -> forced to IDLE, counters cleared, no moves; col/row hold their values.
- x_pos/y_pos: registered, updated one clk after col/row change. Computed at full width and truncated to 12 bits.
- Blink: blink_cnt counts ticks while active, wraps at BLINK_PERIOD-1 -> 0, and is held at 0 while active=0. enable registered = active && (blink_cnt < BLINK_ON). Cursor is therefore visible on the first clk after active rises (1-clk latency).
- Fire: fire_pulse=1 for exactly one clk on a 0->1 edge of synchronized fire while active=1. It is independent of the frame tick. A fire edge while active=0 is discarded, not queued.
- A tick coinciding with a fire edge: both take effect in the same cycle.
- rst asserted mid-operation: next edge returns every output to its reset value, regardless of FSM state.

Test Plan:
- Reset: hold rst 5 clks with buttons pressed -> col=0, row=0, x_pos=32, y_pos=32, enable=0, fire_pulse=0; no move on the first tick after release unless a button is still held.
- Single tap: active=1, btn_right high across 1 tick then released -> col=1, x_pos=80 one clk after col changes, row unchanged, FSM back in IDLE.
- Auto-repeat: hold btn_right through 30 ticks (defaults) -> moves at ticks 1, 21, 27; col=3, x_pos=176.
- Clamp and priority: from col=9, row=0, hold right 40 ticks -> col stays 9 (x_pos=464). Press up+left together -> row stays 0 and col unchanged (up wins).
- Blink/active: active=1 for 64 ticks -> enable high 24 ticks, low 8, repeating. Drop active -> enable=0 next clk and direction presses are ignored.
- Fire: btn_fire held 100 clks -> fire_pulse high exactly 1 clk, 3 clks after press. Repeat with active=0 -> no pulse.
